// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the MEM stage and a word-organised data memory.
// Handles byte/half extraction on loads and read-modify-write for sub-word stores.
module lsu_mem_initiator #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_reg, state_next;
   logic        we_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  off_reg;
   logic [15:0] wdata_reg;

   logic        accept;
   logic        acc_err;
   logic        acc_full_store;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] merged;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:DM_ADDRESS+2];
   assign accept           = (state_reg == IDLE) && req_valid;
   assign acc_full_store   = req_we && (req_funct3 == 3'b010);

   always_comb begin
      acc_err = 1'b1;
      case (req_funct3)
         3'b000:  acc_err = 1'b0;
         3'b001:  acc_err = req_addr[0];
         3'b010:  acc_err = |req_addr[1:0];
         3'b100:  acc_err = req_we;
         3'b101:  acc_err = req_we | req_addr[0];
         default: acc_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) begin
            if (acc_err)             state_next = RESP;
            else if (acc_full_store) state_next = WR;
            else                     state_next = RD;
         end
         RD:   if (mem_ack) state_next = we_reg ? WR : RESP;
         WR:   if (mem_ack) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_reg == IDLE) && !reset;
      mem_req    = (state_reg == RD) || (state_reg == WR);
      mem_we     = (state_reg == WR);
      resp_valid = (state_reg == RESP);
   end

   // Load extraction: byte by offset, half by addr[1]; funct3[2] selects zero-extension.
   assign byte_v = mem_rdata[{off_reg, 3'b000} +: 8];
   assign half_v = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      case (funct3_reg[1:0])
         2'b00:   load_ext = {{24{byte_v[7] & ~funct3_reg[2]}}, byte_v};
         2'b01:   load_ext = {{16{half_v[15] & ~funct3_reg[2]}}, half_v};
         default: load_ext = mem_rdata;
      endcase
   end

   // Store merge: each lane takes new data only if the access covers it.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic lane_hit;
         assign lane_hit = ((funct3_reg[1:0] == 2'b00) && (off_reg == LANE)) ||
                           ((funct3_reg[1:0] == 2'b01) && (off_reg[1] == LANE[1]));
         assign merged[gi*8 +: 8] = !lane_hit ? mem_rdata[gi*8 +: 8] :
                                    (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                                    wdata_reg[(gi%2)*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_reg     <= 1'b0;
         funct3_reg <= 3'b000;
         off_reg    <= 2'b00;
         wdata_reg  <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else if (accept) begin
         we_reg     <= req_we;
         funct3_reg <= req_funct3;
         off_reg    <= req_addr[1:0];
         wdata_reg  <= req_wdata[15:0];
         mem_addr   <= req_addr[DM_ADDRESS+1:2];
         resp_err   <= acc_err;
         resp_rdata <= '0;
         if (acc_full_store) mem_wdata <= req_wdata;
      end else if ((state_reg == RD) && mem_ack) begin
         if (we_reg) mem_wdata  <= merged;
         else        resp_rdata <= load_ext;
      end
   end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomised bench for lsu_mem_initiator: a word memory with programmable ack delay
// and an arithmetic reference model of load extension, store merge and timing.
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic [31:0] mem     [0:511];
   logic [31:0] ref_mem [0:511];
   int ack_delay = 0;
   int ack_cnt   = 0;
   int n_checks  = 0;
   int n_fail    = 0;

   lsu_mem_initiator #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory responder: ack after ack_delay waiting cycles, per request phase.
   always @(negedge clk) begin
      if (mem_req) begin
         if (ack_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            ack_cnt++;
         end
      end else begin
         mem_ack = 1'b0;
         ack_cnt = 0;
      end
   end

   always @(posedge clk) begin
      if (mem_ack && mem_req) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         ack_cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
      bit illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
      bit misal   = ((f3 == 1 || f3 == 5) && a[0]) || ((f3 == 2) && (a[1:0] != 0));
      return illegal || misal;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      logic [31:0] b = (w >> (8 * a[1:0])) & 32'hFF;
      logic [31:0] h = (w >> (16 * a[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w, input logic [31:0] wd);
      logic [31:0] m;
      if (f3 == 0) begin
         m = 32'hFF << (8 * a[1:0]);
         return (w & ~m) | ((wd & 32'hFF) << (8 * a[1:0]));
      end else if (f3 == 1) begin
         m = 32'hFFFF << (16 * a[1]);
         return (w & ~m) | ((wd & 32'hFFFF) << (16 * a[1]));
      end
      return wd;
   endfunction

   task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int dly);
      int idx = int'(addr[10:2]);
      bit err = model_err(we, f3, addr);
      logic [31:0] exp_rd = (err || we) ? 32'h0 : model_load(f3, addr, ref_mem[idx]);
      int exp_lat = err ? 1 : ((we && f3 != 2) ? 2 * dly + 3 : dly + 2);
      int lat = 0;
      bit saw_req = 0;
      ack_delay = dly;
      @(negedge clk);
      check("ready_idle", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = $urandom; req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (mem_req) begin
            saw_req = 1;
            check("mem_addr", 32'(mem_addr), idx);
            check("ready_busy", req_ready, 0);
         end
         if (resp_valid) begin
            lat = c;
            break;
         end
      end
      check("latency", lat, exp_lat);
      check("resp_err", resp_err, err);
      check("resp_rdata", resp_rdata, exp_rd);
      check("mem_req_seen", saw_req, !err);
      if (we && !err) ref_mem[idx] = model_store(f3, addr, ref_mem[idx], wd);
      @(negedge clk);
      check("resp_pulse", resp_valid, 0);
      check("mem_word", mem[idx], ref_mem[idx]);
      $display("op we=%0d f3=%0d addr=%08h wdata=%08h dly=%0d lat=%0d err=%0d rdata=%08h",
               we, f3, addr, wd, dly, lat, resp_err, resp_rdata);
   endtask

   task automatic reset_in_wr();
      bit saw_we = 0;
      int idx = 32;
      ack_delay = 3;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h81; req_wdata = 32'h5A;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 0; c < 40 && !saw_we; c++) begin
         @(negedge clk);
         saw_we = mem_we;
      end
      check("reached_wr", saw_we, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("rst_no_resp", resp_valid, 0);
      end
      reset = 1'b0;
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_word", mem[idx], ref_mem[idx]);
      $display("op reset during SB write, word %08h", mem[idx]);
   endtask

   initial begin
      logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int i = 0; i < 512; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[16] = 32'h8765_43A1;
      ref_mem[16] = 32'h8765_43A1;

      @(negedge clk);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_ready_low", req_ready, 0);
      @(negedge clk);
      reset = 1'b0;

      run_op(0, 3'd0, 32'h42, 0, 0);
      run_op(0, 3'd0, 32'h43, 0, 0);
      run_op(0, 3'd5, 32'h40, 0, 0);
      run_op(0, 3'd1, 32'h42, 0, 0);
      run_op(0, 3'd2, 32'h40, 0, 0);
      run_op(1, 3'd0, 32'h41, 32'h0000_00CC, 0);
      run_op(1, 3'd1, 32'h43, 32'h1234, 0);
      run_op(0, 3'd2, 32'h42, 0, 0);
      run_op(0, 3'd3, 32'h40, 0, 0);
      run_op(1, 3'd4, 32'h40, 32'h77, 0);
      run_op(0, 3'd2, 32'h40, 0, 4);
      run_op(1, 3'd1, 32'h46, 32'hBEEF, 4);
      run_op(1, 3'd2, 32'hFFFF_F844, 32'hCAFE_F00D, 1);
      reset_in_wr();
      run_op(0, 3'd2, 32'h80, 0, 0);

      for (int n = 0; n < 150; n++) begin
         logic [2:0] f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
         logic [31:0] a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         run_op(1'($urandom), f3, a, $urandom, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
